chip8_mem_responder: RTL

Responder end of the chip-8 graphics/sprite memory request protocol. It accepts single-beat read/write requests from one chip-8 initiator (the video engine or CPU, after external muxing) and serves them from a 4 KiB program/sprite RAM and a double-buffered 2x256-byte VRAM. It also drives a second, independent display read port that returns one pixel per cycle from the currently displayed VRAM bank.

---
 rtl/chip8_mem_responder_pkg.sv | 18 +
 rtl/chip8_mem_responder_bram_dp.sv | 53 +++++
 rtl/chip8_mem_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_responder_pkg.sv
// chip8_mem_pkg: memory-type codes, screen geometry and responder states
// shared between the chip-8 memory responder and its initiators.
package chip8_mem_pkg;

  localparam logic MEM_TYPE_RAM  = 1'b0;
  localparam logic MEM_TYPE_VRAM = 1'b1;

  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 32;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_ACK
  } resp_state_t;

endpackage

// File: rtl/chip8_mem_responder_bram_dp.sv
// chip8_bram_dp: true dual-port byte RAM. Port A reads and writes, port B
// only reads. Both read paths run through a free-running register pipeline
// of LAT stages, so data for an address appears LAT clock edges after the
// address is sampled. A port B read of a byte written on the same edge
// returns the old contents.
module chip8_bram_dp #(
  parameter int DEPTH = 256,
  parameter int DW    = 8,
  parameter int LAT   = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic [DW-1:0] o_a_rdata,
  input  logic [AW-1:0] i_b_addr,
  output logic [DW-1:0] o_b_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_qa  [LAT];
  logic [DW-1:0] r_qb  [LAT];

  // Storage array: written from port A only, never cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
  end

  // Read pipelines for both ports; reset clears only the in-flight data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        r_qa[i] <= '0;
        r_qb[i] <= '0;
      end
    end else begin
      r_qa[0] <= r_mem[i_a_addr];
      r_qb[0] <= r_mem[i_b_addr];
      for (int i = 1; i < LAT; i++) begin
        r_qa[i] <= r_qa[i-1];
        r_qb[i] <= r_qb[i-1];
      end
    end
  end

  assign o_a_rdata = r_qa[LAT-1];
  assign o_b_rdata = r_qb[LAT-1];

endmodule

// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder: serves single-beat requests from a chip-8 initiator
// out of a program/sprite RAM and a double-buffered VRAM, and streams one
// pixel per cycle from the displayed VRAM bank on an independent port.
module chip8_mem_responder
  import chip8_mem_pkg::*;
#(
  parameter int RAM_BYTES    = 4096,
  parameter int VRAM_BYTES   = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ad_in,
  input  logic              req_valid_in,
  input  logic [15:0]       req_addr_in,
  input  logic              req_we_in,
  input  logic [BYTE_W-1:0] req_data_in,
  input  logic              req_type_in,
  output logic              ready_out,
  output logic              resp_valid_out,
  output logic [BYTE_W-1:0] resp_data_out,
  input  logic [5:0]        pixel_x_in,
  input  logic [4:0]        pixel_y_in,
  output logic              pixel_out,
  output logic              err_out
);

  localparam int RAM_AW  = $clog2(RAM_BYTES);
  localparam int VRAM_AW = $clog2(VRAM_BYTES);
  localparam int CNT_W   = $clog2(READ_LATENCY + 1);
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_BYTES);

  resp_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ready;
  logic              r_resp_valid;
  logic              r_type;
  logic              r_oob;
  logic              r_err;
  logic [BYTE_W-1:0] r_resp_hold;
  logic [2:0]        r_xlo [READ_LATENCY];

  logic              w_accept;
  logic              w_is_vram;
  logic              w_oob;
  logic              w_ram_we;
  logic              w_vram_we;
  logic [VRAM_AW:0]  w_vram_a_addr;
  logic [VRAM_AW:0]  w_vram_b_addr;
  logic [BYTE_W-1:0] w_ram_a_rdata;
  logic [BYTE_W-1:0] w_ram_b_unused;
  logic [BYTE_W-1:0] w_vram_a_rdata;
  logic [BYTE_W-1:0] w_vram_b_rdata;
  logic [BYTE_W-1:0] w_resp_rdata;

  // Writes commit on the accept edge; the VRAM bank comes from ad_in at that
  // same edge, so later bank flips cannot redirect an accepted request.
  assign w_accept      = req_valid_in & r_ready;
  assign w_is_vram     = (req_type_in == MEM_TYPE_VRAM);
  assign w_oob         = w_is_vram ? (|req_addr_in[15:VRAM_AW])
                                   : ({1'b0, req_addr_in} >= RAM_LIMIT);
  assign w_ram_we      = w_accept & req_we_in & ~w_is_vram & ~w_oob;
  assign w_vram_we     = w_accept & req_we_in &  w_is_vram & ~w_oob;
  assign w_vram_a_addr = {ad_in, req_addr_in[VRAM_AW-1:0]};
  assign w_vram_b_addr = {~ad_in, pixel_y_in, pixel_x_in[5:3]};

  chip8_bram_dp #(
    .DEPTH (RAM_BYTES),
    .DW    (BYTE_W),
    .LAT   (READ_LATENCY)
  ) u_ram (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_a_we    (w_ram_we),
    .i_a_addr  (req_addr_in[RAM_AW-1:0]),
    .i_a_wdata (req_data_in),
    .o_a_rdata (w_ram_a_rdata),
    .i_b_addr  ('0),
    .o_b_rdata (w_ram_b_unused)
  );

  chip8_bram_dp #(
    .DEPTH (2 * VRAM_BYTES),
    .DW    (BYTE_W),
    .LAT   (READ_LATENCY)
  ) u_vram (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_a_we    (w_vram_we),
    .i_a_addr  (w_vram_a_addr),
    .i_a_wdata (req_data_in),
    .o_a_rdata (w_vram_a_rdata),
    .i_b_addr  (w_vram_b_addr),
    .o_b_rdata (w_vram_b_rdata)
  );

  // Request sequencer: accepts in IDLE, counts out the read latency or spends
  // one acknowledge cycle after a write, and keeps the sticky error flag.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_type       <= MEM_TYPE_RAM;
      r_oob        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_type <= w_is_vram;
            r_oob  <= w_oob;
            if (w_oob) begin
              r_err <= 1'b1;
            end
            if (req_we_in) begin
              r_state <= WRITE_ACK;
              r_ready <= 1'b0;
            end else if (READ_LATENCY == 1) begin
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= READ_WAIT;
              r_ready <= 1'b0;
              r_cnt   <= CNT_W'(1);
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WRITE_ACK: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // The read pipeline keeps moving after the response, so the delivered byte
  // is latched here to hold resp_data_out steady until the next response.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_resp_hold <= '0;
    end else if (r_resp_valid) begin
      r_resp_hold <= w_resp_rdata;
    end
  end

  // Column-within-byte travels alongside the pixel read to pick the bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_xlo[i] <= '0;
      end
    end else begin
      r_xlo[0] <= pixel_x_in[2:0];
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_xlo[i] <= r_xlo[i-1];
      end
    end
  end

  assign w_resp_rdata   = r_oob ? '0 : (r_type ? w_vram_a_rdata : w_ram_a_rdata);
  assign ready_out      = r_ready;
  assign resp_valid_out = r_resp_valid;
  assign resp_data_out  = r_resp_valid ? w_resp_rdata : r_resp_hold;
  assign pixel_out      = w_vram_b_rdata[3'd7 - r_xlo[READ_LATENCY-1]];
  assign err_out        = r_err;

endmodule
